mips_dmem_responder: RTL and testbench

Word-organised data-memory responder that answers load/store requests issued by the `mips` core's memory stage over a single-outstanding req/ack handshake. It sits on the core's data port in place of an ideal zero-latency memory. It inserts a programmable number of wait states so the core's stall logic can be exercised under `testbench`. Byte enables support `sb`/`sh`/`sw`.

---
 rtl/mips_dmem_responder.sv | 156 +++++++++++++++
 tb/tb_mips_dmem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - word-organised data memory responder with programmable wait states
//
// Answers single-outstanding load/store requests from the core's memory stage.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req, we         : request valid, 1 = store / 0 = load (sampled in IDLE only)
//   addr, wdata, be : byte address, store data, byte enables (captured with req)
//   ack             : one-cycle response strobe
//   rdata, err      : load data / error flag, both zero outside the ack cycle
//   busy            : high from the capture edge until the edge that ends the response
// Parameters: DEPTH_LOG2 (log2 words), WAIT (0..15 wait cycles).
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned requests with err.

module mips_dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  cap_we;
    logic                  cap_bad;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [31:0]           cap_wdata;
    logic [3:0]            cap_be;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_bad;

    // Upper address bits alias onto the array; the low two bits only feed the
    // optional alignment check.
    logic                  unused_addr;

    assign req_idx     = addr[DEPTH_LOG2+1:2];
    assign unused_addr = &{1'b0, addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] a, input logic [3:0] b);
        case (b)
            4'b1111:                            return (a != 2'b00);
            4'b0011, 4'b1100:                   return a[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b0;
            default:                            return 1'b1;
        endcase
    endfunction

    assign req_bad = misaligned(addr[1:0], be);
`else
    assign req_bad = 1'b0;
`endif

    // The response registers are loaded on the edge that enters RESP. With
    // WAIT=0 that edge is also the capture edge, so the live request inputs
    // are used instead of the captured copies.
    logic                  enter_resp;
    logic                  resp_we;
    logic                  resp_bad;
    logic [DEPTH_LOG2-1:0] resp_idx;

    always_comb begin
        enter_resp = 1'b0;
        resp_we    = cap_we;
        resp_bad   = cap_bad;
        resp_idx   = cap_idx;
        if (state == S_IDLE) begin
            enter_resp = req && (WAIT_INIT == 4'd0);
            resp_we    = we;
            resp_bad   = req_bad;
            resp_idx   = req_idx;
        end else if (state == S_WAIT) begin
            enter_resp = (cnt == 4'd1);
        end
    end

    // Store commits on the edge that ends RESP, so a load captured right
    // afterwards already sees the new data. Reset suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RESP && cap_we && !cap_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ack       <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cap_we    <= 1'b0;
            cap_bad   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_bad   <= req_bad;
                        cap_idx   <= req_idx;
                        cap_wdata <= wdata;
                        cap_be    <= be;
                        cnt       <= WAIT_INIT;
                        busy      <= 1'b1;
                        state     <= (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            ack   <= enter_resp;
            err   <= enter_resp && resp_bad;
            rdata <= (enter_resp && !resp_we && !resp_bad) ? mem[resp_idx] : 32'd0;
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb/tb_mips_dmem_responder.sv - directed self-checking bench for mips_dmem_responder

module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // WAIT=2 instance
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    // WAIT=0 instance
    logic        req0 = 1'b0;
    logic        we0 = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic        ack0;
    logic [31:0] rdata0;
    logic        err0;
    logic        busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_dmem_responder #(.DEPTH_LOG2(10), .WAIT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    mips_dmem_responder #(.DEPTH_LOG2(10), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    // One transaction on the WAIT=2 instance. lat counts negedges after the
    // capture edge until ack is seen (0 = no ack within the budget).
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic e,
                       output int lat);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; rd = '0; e = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i; rd = rdata; e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: ack=%b busy=%b rdata=%h err=%b, required 0", i, ack, busy, rdata, err);
            end
        end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture: ack=%b busy=%b, required 0 0", ack, busy);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int lat;
        // busy tracked by hand for the store
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL store_busy: busy=%b ack=%b, required 1 0", busy, ack);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || busy !== 1'b1 || rdata !== 32'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL store_ack_latency: ack=%b busy=%b rdata=%h err=%b, required 1 1 0 0", ack, busy, rdata, err);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL store_ack_width: ack=%b busy=%b, required 0 0", ack, busy);
        end

        txn(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (lat !== 3 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL load_after_store: lat=%0d rdata=%h err=%b, required 3 deadbeef 0", lat, rd, e);
        end

        // 0x1010 aliases onto word 0x10 with a 1024-word array
        txn(1'b0, 32'h1010, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (lat !== 3 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_alias: lat=%0d rdata=%h, required 3 deadbeef", lat, rd);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
        txn(1'b1, 32'h20, 32'h000000AA, 4'b0001, rd, e, lat);
        txn(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== 32'h112233AA) begin
            errors++;
            $display("FAIL byte_store: rdata=%h, required 112233aa", rd);
        end
        txn(1'b1, 32'h20, 32'hBBCC0000, 4'b1100, rd, e, lat);
        txn(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== 32'hBBCC33AA) begin
            errors++;
            $display("FAIL half_store: rdata=%h, required bbcc33aa", rd);
        end
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
        checks++;
`ifdef DMEM_ALIGN_CHECK_EN
        if (lat !== 3 || e !== 1'b1) begin
            errors++;
            $display("FAIL be_zero_ack: lat=%0d err=%b, required 3 1", lat, e);
        end
`else
        if (lat !== 3 || e !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_ack: lat=%0d err=%b, required 3 0", lat, e);
        end
`endif
        txn(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (rd !== 32'hBBCC33AA) begin
            errors++;
            $display("FAIL be_zero_data: rdata=%h, required bbcc33aa", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_tab [3];
        logic [31:0] d_tab [3];
        int acks;
        a_tab[0] = 32'h100; a_tab[1] = 32'h104; a_tab[2] = 32'h108;
        d_tab[0] = 32'hA1A1A1A1; d_tab[1] = 32'hB2B2B2B2; d_tab[2] = 32'hC3C3C3C3;
        for (int pass = 0; pass < 2; pass++) begin
            acks = 0;
            @(negedge clk);
            req0 = 1'b1; we0 = (pass == 0); be0 = 4'hF;
            addr0 = a_tab[0]; wdata0 = d_tab[0];
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                checks++;
                if (ack0 !== ((c % 2) == 0)) begin
                    errors++;
                    $display("FAIL b2b_ack_pattern pass %0d cycle %0d: ack=%b, required %b", pass, c, ack0, ((c % 2) == 0));
                end
                if (ack0 === 1'b1 && acks < 3) begin
                    checks++;
                    if (rdata0 !== ((pass == 0) ? 32'd0 : d_tab[acks])) begin
                        errors++;
                        $display("FAIL b2b_rdata pass %0d ack %0d: rdata=%h, required %h", pass, acks, rdata0, (pass == 0) ? 32'd0 : d_tab[acks]);
                    end
                    acks++;
                    if (acks < 3) begin
                        addr0 = a_tab[acks]; wdata0 = d_tab[acks];
                    end else begin
                        req0 = 1'b0;
                    end
                end
            end
            req0 = 1'b0;
            checks++;
            if (acks !== 3) begin
                errors++;
                $display("FAIL b2b_ack_count pass %0d: acks=%0d, required 3", pass, acks);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 32'h30, 32'h0, 4'hF, rd, e, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h55; be = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_ack cycle %0d: ack=%b busy=%b, required 0 0", i, ack, busy);
            end
        end
        rst = 1'b0;
        txn(1'b0, 32'h30, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (lat !== 3 || rd !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_write: lat=%0d rdata=%h, required 3 00000000", lat, rd);
        end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, e, lat);
        txn(1'b1, 32'h42, 32'h12345678, 4'hF, rd, e, lat);
        checks++;
`ifdef DMEM_ALIGN_CHECK_EN
        if (lat !== 3 || e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL align_err: lat=%0d err=%b rdata=%h, required 3 1 0", lat, e, rd);
        end
`else
        if (lat !== 3 || e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL align_err: lat=%0d err=%b rdata=%h, required 3 0 0", lat, e, rd);
        end
`endif
        txn(1'b0, 32'h40, 32'h0, 4'hF, rd, e, lat);
        checks++;
`ifdef DMEM_ALIGN_CHECK_EN
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL align_data: rdata=%h, required cafef00d", rd);
        end
`else
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL align_data: rdata=%h, required 12345678", rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_back_to_back();
        test_abort();
        test_align();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
